// File: rtl/nanorv32_csr_cnt.sv
// Counter CSR block: cycle/time/instret plus NUM_EVT hpm counters, M-mode write/set/clear, mcountinhibit.
// Define NANORV32_CSR_CNT_OVF_IRQ_EN for sticky overflow flags at CSR 0x7C0 and a registered irq_ovf.
module nanorv32_csr_cnt #(
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVT    = 4,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [CSR_ADDR_W-1:0]                 csr_addr,
  input  logic [31:0]                           csr_wdata,
  input  logic                                  csr_wr,
  input  logic [1:0]                            csr_op,
  output logic [31:0]                           csr_rdata,
  output logic                                  csr_hit,
  input  logic                                  force_stall_reset,
  input  logic                                  stall_exe,
  input  logic [((NUM_EVT > 0) ? NUM_EVT : 1)-1:0] evt_in,
  output logic                                  irq_ovf
);

  localparam int EVT_W = (NUM_EVT > 0) ? NUM_EVT : 1;
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_EVT) - 32'h1) << 3);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CSR_ADDR_W-1:0] addr_of(input int unsigned a);
    return CSR_ADDR_W'(a);
  endfunction

  function automatic logic [31:0] csr_alu(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] op);
    case (op)
      2'b00:   return wd;
      2'b01:   return old | wd;
      2'b10:   return old & ~wd;
      default: return old;
    endcase
  endfunction

  // Works on a 64-bit zero-extended view so the high half of narrow counters just truncates.
  function automatic logic [CNT_WIDTH-1:0] wr_half(input logic [CNT_WIDTH-1:0] cnt, input logic hi,
                                                   input logic [31:0] wd, input logic [1:0] op);
    logic [63:0] ext;
    ext = 64'(cnt);
    if (hi) ext[63:32] = csr_alu(ext[63:32], wd, op);
    else    ext[31:0]  = csr_alu(ext[31:0], wd, op);
    return ext[CNT_WIDTH-1:0];
  endfunction

  function automatic logic [31:0] hi32(input logic [CNT_WIDTH-1:0] v);
    logic [63:0] ext;
    ext = 64'(v);
    return ext[63:32];
  endfunction

  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] time_q, time_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;
  logic [CNT_WIDTH-1:0] hpm_q [EVT_W];
  logic [CNT_WIDTH-1:0] hpm_d [EVT_W];
  logic [31:0]          inhibit_q, inhibit_d;

  logic             wr_en, cy_wr, ir_wr;
  logic             tm_inc, cy_inc, ir_inc;
  logic [EVT_W-1:0] hpm_wr, hpm_inc;

  // A write to either half suppresses that counter's increment for the cycle.
  always_comb begin
    wr_en   = csr_wr && (csr_op != 2'b11);
    cy_wr   = wr_en && (csr_addr == addr_of(32'hB00) || csr_addr == addr_of(32'hB80));
    ir_wr   = wr_en && (csr_addr == addr_of(32'hB02) || csr_addr == addr_of(32'hB82));
    tm_inc  = !force_stall_reset;
    cy_inc  = tm_inc && !inhibit_q[0] && !cy_wr;
    ir_inc  = tm_inc && !stall_exe && !inhibit_q[2] && !ir_wr;
    hpm_wr  = '0;
    hpm_inc = '0;
    for (int i = 0; i < NUM_EVT; i++) begin
      hpm_wr[i]  = wr_en && (csr_addr == addr_of(32'hB03 + i) || csr_addr == addr_of(32'hB83 + i));
      hpm_inc[i] = evt_in[i] && tm_inc && !inhibit_q[3+i] && !hpm_wr[i];
    end
  end

  always_comb begin
    cycle_d   = cycle_q;
    time_d    = time_q;
    instret_d = instret_q;
    inhibit_d = inhibit_q;
    for (int i = 0; i < EVT_W; i++) hpm_d[i] = hpm_q[i];

    if (tm_inc) time_d    = time_q + CNT_ONE;
    if (cy_inc) cycle_d   = cycle_q + CNT_ONE;
    if (ir_inc) instret_d = instret_q + CNT_ONE;

    if (wr_en) begin
      if (csr_addr == addr_of(32'hB00)) cycle_d   = wr_half(cycle_q, 1'b0, csr_wdata, csr_op);
      if (csr_addr == addr_of(32'hB80)) cycle_d   = wr_half(cycle_q, 1'b1, csr_wdata, csr_op);
      if (csr_addr == addr_of(32'hB02)) instret_d = wr_half(instret_q, 1'b0, csr_wdata, csr_op);
      if (csr_addr == addr_of(32'hB82)) instret_d = wr_half(instret_q, 1'b1, csr_wdata, csr_op);
      if (csr_addr == addr_of(32'h320)) inhibit_d = csr_alu(inhibit_q, csr_wdata, csr_op) & INH_MASK;
    end

    for (int i = 0; i < NUM_EVT; i++) begin
      if (hpm_inc[i]) hpm_d[i] = hpm_q[i] + CNT_ONE;
      if (wr_en && csr_addr == addr_of(32'hB03 + i))
        hpm_d[i] = wr_half(hpm_q[i], 1'b0, csr_wdata, csr_op);
      if (wr_en && csr_addr == addr_of(32'hB83 + i))
        hpm_d[i] = wr_half(hpm_q[i], 1'b1, csr_wdata, csr_op);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      time_q    <= '0;
      instret_q <= '0;
      inhibit_q <= '0;
      for (int i = 0; i < EVT_W; i++) hpm_q[i] <= '0;
    end else begin
      cycle_q   <= cycle_d;
      time_q    <= time_d;
      instret_q <= instret_d;
      inhibit_q <= inhibit_d;
      for (int i = 0; i < EVT_W; i++) hpm_q[i] <= hpm_d[i];
    end
  end

`ifdef NANORV32_CSR_CNT_OVF_IRQ_EN
  logic [31:0] ovf_q, ovf_d;
  logic        irq_ovf_q, irq_ovf_d;

  // Sets are applied after the clear so a same-cycle wrap keeps its flag.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_en && csr_op != 2'b10 && csr_addr == addr_of(32'h7C0)) ovf_d = ovf_q & ~csr_wdata;
    if (cy_inc && (&cycle_q))   ovf_d[0] = 1'b1;
    if (ir_inc && (&instret_q)) ovf_d[2] = 1'b1;
    for (int i = 0; i < NUM_EVT; i++) begin
      if (hpm_inc[i] && (&hpm_q[i])) ovf_d[3+i] = 1'b1;
    end
    irq_ovf_d = |ovf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q     <= '0;
      irq_ovf_q <= 1'b0;
    end else begin
      ovf_q     <= ovf_d;
      irq_ovf_q <= irq_ovf_d;
    end
  end

  assign irq_ovf = irq_ovf_q;
`else
  assign irq_ovf = 1'b0;
`endif

  always_comb begin
    csr_rdata = '0;
    csr_hit   = 1'b0;
    if (csr_addr == addr_of(32'hC00) || csr_addr == addr_of(32'hB00)) begin
      csr_hit = 1'b1; csr_rdata = cycle_q[31:0];
    end
    if (csr_addr == addr_of(32'hC80) || csr_addr == addr_of(32'hB80)) begin
      csr_hit = 1'b1; csr_rdata = hi32(cycle_q);
    end
    if (csr_addr == addr_of(32'hC01)) begin
      csr_hit = 1'b1; csr_rdata = time_q[31:0];
    end
    if (csr_addr == addr_of(32'hC81)) begin
      csr_hit = 1'b1; csr_rdata = hi32(time_q);
    end
    if (csr_addr == addr_of(32'hC02) || csr_addr == addr_of(32'hB02)) begin
      csr_hit = 1'b1; csr_rdata = instret_q[31:0];
    end
    if (csr_addr == addr_of(32'hC82) || csr_addr == addr_of(32'hB82)) begin
      csr_hit = 1'b1; csr_rdata = hi32(instret_q);
    end
    if (csr_addr == addr_of(32'h320)) begin
      csr_hit = 1'b1; csr_rdata = inhibit_q;
    end
    for (int i = 0; i < NUM_EVT; i++) begin
      if (csr_addr == addr_of(32'hC03 + i) || csr_addr == addr_of(32'hB03 + i)) begin
        csr_hit = 1'b1; csr_rdata = hpm_q[i][31:0];
      end
      if (csr_addr == addr_of(32'hC83 + i) || csr_addr == addr_of(32'hB83 + i)) begin
        csr_hit = 1'b1; csr_rdata = hi32(hpm_q[i]);
      end
    end
`ifdef NANORV32_CSR_CNT_OVF_IRQ_EN
    if (csr_addr == addr_of(32'h7C0)) begin
      csr_hit = 1'b1; csr_rdata = ovf_q;
    end
`endif
  end

endmodule

// File: tb/tb_nanorv32_csr_cnt.sv
// Directed bench for nanorv32_csr_cnt: 64-bit/4-event instance plus a 40-bit instance on shared stimulus.
module tb_nanorv32_csr_cnt;
  logic        clk, rst_n;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wr;
  logic [1:0]  csr_op;
  logic        force_stall_reset, stall_exe;
  logic [3:0]  evt_in;
  logic [31:0] csr_rdata, rdata40;
  logic        csr_hit, hit40, irq_ovf, irq40;
  int          n_chk, n_fail;

  nanorv32_csr_cnt #(.CNT_WIDTH(64), .NUM_EVT(4), .CSR_ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wr(csr_wr),
    .csr_op(csr_op), .csr_rdata(csr_rdata), .csr_hit(csr_hit),
    .force_stall_reset(force_stall_reset), .stall_exe(stall_exe), .evt_in(evt_in),
    .irq_ovf(irq_ovf)
  );

  nanorv32_csr_cnt #(.CNT_WIDTH(40), .NUM_EVT(4), .CSR_ADDR_W(12)) dut40 (
    .clk(clk), .rst_n(rst_n), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wr(csr_wr),
    .csr_op(csr_op), .csr_rdata(rdata40), .csr_hit(hit40),
    .force_stall_reset(force_stall_reset), .stall_exe(stall_exe), .evt_in(evt_in),
    .irq_ovf(irq40)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a);
    csr_addr = a;
    #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    csr_addr  = a;
    csr_op    = op;
    csr_wdata = wd;
    csr_wr    = 1'b1;
    cyc(1);
    csr_wr = 1'b0;
    csr_op = 2'b11;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; force_stall_reset = 1'b1; stall_exe = 1'b0; evt_in = 4'b0;
    csr_addr = 12'h000; csr_wdata = 32'h0; csr_wr = 1'b0; csr_op = 2'b11;

    rd(12'hC00); chk("rst_cycle", csr_rdata, 32'h0); chk("rst_hit", 32'(csr_hit), 32'h1);
    rd(12'hC82); chk("rst_instret_hi", csr_rdata, 32'h0);
    rd(12'h320); chk("rst_inhibit", csr_rdata, 32'h0);
    chk("rst_irq", 32'(irq_ovf), 32'h0);
    chk("rst_irq40", 32'(irq40), 32'h0);
    rst_n = 1'b1;

    cyc(5);
    force_stall_reset = 1'b0;
    cyc(10);
    rd(12'hC00); chk("boot_cycle", csr_rdata, 32'd10);
    rd(12'hC01); chk("boot_time", csr_rdata, 32'd10);
    rd(12'hC02); chk("boot_instret", csr_rdata, 32'd10);
    force_stall_reset = 1'b1;

    wr(12'hB80, 2'b00, 32'h1);
    wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
    rd(12'hB80); chk("mcycle_hi", csr_rdata, 32'h1);
    rd(12'hB00); chk("mcycle_lo", csr_rdata, 32'hFFFF_FFFF);
    force_stall_reset = 1'b0;
    cyc(1);
    rd(12'hB80); chk("carry_hi", csr_rdata, 32'h2);
    rd(12'hB00); chk("carry_lo", csr_rdata, 32'h0);
    wr(12'hB00, 2'b00, 32'h5);
    force_stall_reset = 1'b1;
    rd(12'hB00); chk("wr_wins_lo", csr_rdata, 32'h5);
    rd(12'hB80); chk("wr_wins_hi", csr_rdata, 32'h2);
    rd(12'hC01); chk("time_12", csr_rdata, 32'd12);
    rd(12'hC02); chk("instret_12", csr_rdata, 32'd12);

    wr(12'h320, 2'b00, 32'h5);
    rd(12'h320); chk("inh_wr", csr_rdata, 32'h5);
    wr(12'h320, 2'b01, 32'h2);
    rd(12'h320); chk("inh_bit1_ro", csr_rdata, 32'h5);
    force_stall_reset = 1'b0;
    cyc(4);
    rd(12'hC00); chk("inh_cycle", csr_rdata, 32'h5);
    rd(12'hC02); chk("inh_instret", csr_rdata, 32'd12);
    rd(12'hC01); chk("inh_time", csr_rdata, 32'd16);
    wr(12'h320, 2'b10, 32'h5);
    rd(12'hC00); chk("inh_old_used", csr_rdata, 32'h5);
    rd(12'hC01); chk("inh_time17", csr_rdata, 32'd17);
    rd(12'h320); chk("inh_cleared", csr_rdata, 32'h0);
    cyc(1);
    force_stall_reset = 1'b1;
    rd(12'hC00); chk("resume_cycle", csr_rdata, 32'h6);
    rd(12'hC02); chk("resume_instret", csr_rdata, 32'd13);
    rd(12'hC01); chk("resume_time", csr_rdata, 32'd18);

    force_stall_reset = 1'b0;
    evt_in = 4'b1010;
    cyc(3);
    evt_in = 4'b0000;
    force_stall_reset = 1'b1;
    rd(12'hC03); chk("hpm3", csr_rdata, 32'h0);
    rd(12'hC04); chk("hpm4", csr_rdata, 32'h3);
    rd(12'hC05); chk("hpm5", csr_rdata, 32'h0);
    rd(12'hC06); chk("hpm6", csr_rdata, 32'h3);
    rd(12'hB06); chk("mhpm6", csr_rdata, 32'h3);
    rd(12'hC07); chk("unmap_rdata", csr_rdata, 32'h0); chk("unmap_hit", 32'(csr_hit), 32'h0);
    rd(12'hC00); chk("evt_cycle", csr_rdata, 32'h9);

    force_stall_reset = 1'b0;
    wr(12'hC00, 2'b00, 32'h1234);
    force_stall_reset = 1'b1;
    rd(12'hC00); chk("ro_ignored", csr_rdata, 32'hA); chk("ro_hit", 32'(csr_hit), 32'h1);
    rd(12'hC01); chk("time_22", csr_rdata, 32'd22);
    wr(12'hB03, 2'b01, 32'h10);
    wr(12'hB04, 2'b10, 32'h1);
    wr(12'hB05, 2'b11, 32'hFF);
    rd(12'hC03); chk("hpm3_set", csr_rdata, 32'h10);
    rd(12'hC04); chk("hpm4_clr", csr_rdata, 32'h2);
    rd(12'hC05); chk("hpm5_nop", csr_rdata, 32'h0);

    wr(12'hB80, 2'b00, 32'hFFFF_FFFF);
    rd(12'hB80); chk("w64_hi", csr_rdata, 32'hFFFF_FFFF); chk("w40_hi", rdata40, 32'h0000_00FF);
    chk("w40_hit", 32'(hit40), 32'h1);
    wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
    force_stall_reset = 1'b0;
    cyc(1);
    force_stall_reset = 1'b1;
    rd(12'hC80); chk("wrap64_hi", csr_rdata, 32'h0); chk("wrap40_hi", rdata40, 32'h0);
    rd(12'hC00); chk("wrap64_lo", csr_rdata, 32'h0); chk("wrap40_lo", rdata40, 32'h0);

`ifdef NANORV32_CSR_CNT_OVF_IRQ_EN
    rd(12'h7C0); chk("ovf_cycle", csr_rdata, 32'h1); chk("ovf_hit", 32'(csr_hit), 32'h1);
    wr(12'h7C0, 2'b00, 32'hFFFF_FFFF);
    wr(12'hB82, 2'b00, 32'hFFFF_FFFF);
    wr(12'hB02, 2'b00, 32'hFFFF_FFFF);
    rd(12'h7C0); chk("ovf_wr0_noset", csr_rdata, 32'h0);
    chk("irq_quiet", 32'(irq_ovf), 32'h0);
    force_stall_reset = 1'b0;
    cyc(1);
    force_stall_reset = 1'b1;
    rd(12'h7C0); chk("ovf_ir", csr_rdata, 32'h4);
    cyc(1);
    chk("irq_set", 32'(irq_ovf), 32'h1);
    wr(12'h7C0, 2'b10, 32'h4);
    rd(12'h7C0); chk("ovf_op10_ign", csr_rdata, 32'h4);
    wr(12'h7C0, 2'b00, 32'h4);
    cyc(1);
    rd(12'h7C0); chk("ovf_clr", csr_rdata, 32'h0);
    chk("irq_clr", 32'(irq_ovf), 32'h0);
`else
    rd(12'h7C0); chk("x7c0_rdata", csr_rdata, 32'h0); chk("x7c0_hit", 32'(csr_hit), 32'h0);
    cyc(1);
    chk("irq_tied", 32'(irq_ovf), 32'h0);
`endif

    force_stall_reset = 1'b0;
    cyc(3);
    #2 rst_n = 1'b0;
    rd(12'hC01); chk("arst_time", csr_rdata, 32'h0);
    rd(12'hB03); chk("arst_hpm3", csr_rdata, 32'h0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
